host_mem_link: RTL and testbench
================================

// Module: host_mem_link
// PURPOSE
//  Hardware host-side master for top_control's external memory port (addr_ext, iram/dram_write_ext, read_en_ext, start..start_4).
//  Consumes a 16-bit command word stream: loads IRAM, loads DRAM, runs the processor for a cycle budget, reads DRAM back.
//  Read-back words and acks go out on a 16-bit response stream.
//  Sits between a host link (UART/JTAG word bridge) and top_control; replaces the file-driven bench loader on silicon.
// PARAMETERS
//  ADDR_W     9    external address width
//  DATA_W     16   word width of memories and both streams
//  WR_SETUP   2    cycles addr/data are stable before the write strobe rises
//  WR_PULSE   4    cycles the write strobe is held high
//  RD_LAT     5    cycles from read_en_ext high to dram_in sample
//  RUN_SCALE  256  processor cycles per RUN count unit
// PORTS
//  clock           in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high reset
//  cmd_data        in   DATA_W  command/argument/payload word
//  cmd_valid       in   1       cmd_data valid
//  cmd_ready       out  1       word accepted when valid&ready
//  rsp_data        out  DATA_W  read-back word or ack/error word
//  rsp_valid       out  1       rsp_data valid; held with data stable until rsp_ready
//  rsp_ready       in   1       downstream accepts rsp_data
//  start           out  1       processor run enable
//  start_2         out  1       IRAM external-load mode
//  start_3         out  1       DRAM external-load mode
//  start_4         out  1       DRAM external-read mode
//  addr_ext        out  ADDR_W  external memory address
//  iram_write_ext  out  1       IRAM write strobe
//  dram_write_ext  out  1       DRAM write strobe
//  read_en_ext     out  1       DRAM read enable
//  Data_in_ins     out  DATA_W  IRAM write data
//  Data_in_dram    out  DATA_W  DRAM write data
//  dram_in         in   DATA_W  DRAM read data
// BEHAVIOUR
//  - Reset (async): all outputs 0, except cmd_ready=1; FSM in IDLE. Reset mid-operation drops every strobe/mode at once; no ack.
//  - Command = 2 words: W0 = {op[15:12], 3'b0, addr[8:0]}, W1 = N (16-bit).
//    op 1 LOAD_IRAM, 2 LOAD_DRAM (N payload words follow), 3 RUN, 4 READ_DRAM.
//  - States: IDLE -> ARG -> MODE_ON -> {DATA, SETUP, PULSE, HOLD} | RUN | {RD_REQ, RD_WAIT, RD_SEND} -> MODE_OFF -> ACK -> IDLE.
//  - cmd_ready is high only in IDLE, ARG and DATA.
//  - MODE_ON: assert exactly one mode (start_2/start_3/start, or start_4) one cycle before the first access; mode stays high
//    through the whole command. Modes are mutually exclusive. MODE_OFF forces >=1 cycle with all modes low before ACK.
//  - Load, per word:
//    DATA: accept word -> Data_in_ins (op1) or Data_in_dram (op2); addr_ext = current address.
//    SETUP: WR_SETUP cycles.
//    PULSE: strobe high WR_PULSE cycles.
//    HOLD: 1 cycle strobe low, addr/data unchanged; then addr_ext += 1.
//  - RUN: start high N*RUN_SCALE cycles exactly (32-bit counter), then low.
//  - READ, per word:
//    RD_REQ: read_en_ext=1.
//    RD_WAIT: after RD_LAT cycles, capture dram_in.
//    RD_SEND: read_en_ext=0; rsp_valid=1 until rsp_ready; then addr+1.
//  - Address arithmetic is modulo 2^ADDR_W (511 -> 0 wraps silently).
//  - ACK: rsp_data = {4'hA, op, 8'h00}. Held under backpressure.
//  - Boundary cases:
//    N=0: no accesses, no mode pulse; ACK follows ARG directly.
//    op 0 or >4: rsp 16'hE000 after W0, W1 not consumed, back to IDLE.
//    rsp_ready low: FSM stalls, read_en_ext stays low, address frozen.
//    cmd_valid low mid-load: stall in DATA, strobes low, mode stays high.
//  - Latency: load word = 1 + WR_SETUP + WR_PULSE + 1 cycles from acceptance; read word = RD_LAT + 2 cycles min.
// TESTING
//  1 LOAD_IRAM: 0x1001, 3, 10, 20, 30 -> start_2 high; writes at addr 1,2,3 with data 10/20/30, each strobe 4 cycles; rsp 0xA100.
//  2 LOAD_DRAM at 511, N=2 -> writes at 511 then 0 (wrap); start_2 never high; rsp 0xA200.
//  3 RUN N=4 -> start high exactly 1024 cycles; >=1 idle cycle; rsp 0xA300.
//  4 READ 0x4005, N=3 with dram model returning addr*3 -> rsp 15,18,21 then 0xA400; rsp_ready held low 10 cycles on word 2:
//    data stable, no extra read_en_ext.
//  5 Opcode 0x7xxx -> rsp 0xE000; next valid command executes normally. N=0 LOAD -> no strobes, immediate 0xA100.
//  6 Reset pulse mid-PULSE -> all strobes/modes 0 in the same cycle (async); cmd_ready=1; no ack emitted.

Source files
------------

// File: rtl/host_mem_link.sv
// host_mem_link: host-side command master driving top_control's external IRAM/DRAM port.
// Two-word commands load memories, run the core for N*RUN_SCALE cycles, or stream DRAM back.
module host_mem_link #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int WR_SETUP  = 2,
  parameter int WR_PULSE  = 4,
  parameter int RD_LAT    = 5,
  parameter int RUN_SCALE = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              start,
  output logic              start_2,
  output logic              start_3,
  output logic              start_4,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              iram_write_ext,
  output logic              dram_write_ext,
  output logic              read_en_ext,
  output logic [DATA_W-1:0] Data_in_ins,
  output logic [DATA_W-1:0] Data_in_dram,
  input  logic [DATA_W-1:0] dram_in
);
  typedef enum logic [3:0] {
    IDLE, ARG, MODE_ON, DATA, SETUP, PULSE, HOLD, RUN, RD_REQ, RD_WAIT, RD_SEND, MODE_OFF, ACK
  } state_t;
  state_t state, state_n;
  logic [3:0] op, op_n, cmd_op;
  logic err, err_n, active;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] cnt, cnt_n, ins, ins_n, dram, dram_n, rd, rd_n;
  logic [31:0] tmr, tmr_n;
  assign cmd_op = cmd_data[DATA_W-1:DATA_W-4];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      op <= '0;
      err <= 1'b0;
      addr <= '0;
      cnt <= '0;
      tmr <= '0;
      ins <= '0;
      dram <= '0;
      rd <= '0;
    end else begin
      state <= state_n;
      op <= op_n;
      err <= err_n;
      addr <= addr_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      ins <= ins_n;
      dram <= dram_n;
      rd <= rd_n;
    end
  always_comb begin
    state_n = state;
    op_n = op;
    err_n = err;
    addr_n = addr;
    cnt_n = cnt;
    tmr_n = tmr;
    ins_n = ins;
    dram_n = dram;
    rd_n = rd;
    case (state)
      IDLE: if (cmd_valid) begin
        op_n = cmd_op;
        addr_n = cmd_data[ADDR_W-1:0];
        err_n = cmd_op == 4'd0 || cmd_op > 4'd4;
        state_n = err_n ? ACK : ARG;
      end
      ARG: if (cmd_valid) begin
        cnt_n = cmd_data;
        state_n = cmd_data == '0 ? ACK : MODE_ON;
      end
      MODE_ON: begin
        // mode cycle counts toward the run budget, so RUN lasts one cycle less
        tmr_n = 32'(cnt) * 32'(RUN_SCALE) - 32'd2;
        state_n = op == 4'd3 ? RUN : op == 4'd4 ? RD_REQ : DATA;
      end
      DATA: if (cmd_valid) begin
        ins_n = op == 4'd1 ? cmd_data : ins;
        dram_n = op == 4'd2 ? cmd_data : dram;
        tmr_n = 32'(WR_SETUP - 1);
        state_n = SETUP;
      end
      SETUP: begin
        tmr_n = tmr == '0 ? 32'(WR_PULSE - 1) : tmr - 32'd1;
        state_n = tmr == '0 ? PULSE : SETUP;
      end
      PULSE: begin
        tmr_n = tmr - 32'd1;
        state_n = tmr == '0 ? HOLD : PULSE;
      end
      HOLD: begin
        addr_n = addr + ADDR_W'(1);
        cnt_n = cnt - DATA_W'(1);
        state_n = cnt == DATA_W'(1) ? MODE_OFF : DATA;
      end
      RUN: begin
        tmr_n = tmr - 32'd1;
        state_n = tmr == '0 ? MODE_OFF : RUN;
      end
      RD_REQ: begin
        tmr_n = 32'(RD_LAT - 1);
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        tmr_n = tmr - 32'd1;
        rd_n = tmr == '0 ? dram_in : rd;
        state_n = tmr == '0 ? RD_SEND : RD_WAIT;
      end
      RD_SEND: if (rsp_ready) begin
        addr_n = addr + ADDR_W'(1);
        cnt_n = cnt - DATA_W'(1);
        state_n = cnt == DATA_W'(1) ? MODE_OFF : RD_REQ;
      end
      MODE_OFF: state_n = ACK;
      ACK: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign active = state inside {MODE_ON, DATA, SETUP, PULSE, HOLD, RUN, RD_REQ, RD_WAIT, RD_SEND};
  assign start = active && op == 4'd3;
  assign start_2 = active && op == 4'd1;
  assign start_3 = active && op == 4'd2;
  assign start_4 = active && op == 4'd4;
  assign cmd_ready = state inside {IDLE, ARG, DATA};
  assign rsp_valid = state inside {RD_SEND, ACK};
  assign rsp_data = state == RD_SEND ? rd : state == ACK ? (err ? 16'hE000 : {4'hA, op, 8'h00}) : '0;
  assign iram_write_ext = state == PULSE && op == 4'd1;
  assign dram_write_ext = state == PULSE && op == 4'd2;
  assign read_en_ext = state inside {RD_REQ, RD_WAIT};
  assign addr_ext = addr;
  assign Data_in_ins = ins;
  assign Data_in_dram = dram;
endmodule

// File: tb/tb_host_mem_link.sv
// tb_host_mem_link: table vectors, hand sequences and random commands against a transaction-level model.
module tb_host_mem_link;
  localparam int WR_SETUP = 2, WR_PULSE = 4, SCALE = 256;
  logic clock = 1'b0, reset = 1'b1;
  logic [15:0] cmd_data = '0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [15:0] rsp_data;
  logic rsp_valid, rsp_ready = 1'b0;
  logic start, start_2, start_3, start_4;
  logic [8:0] addr_ext;
  logic iram_write_ext, dram_write_ext, read_en_ext;
  logic [15:0] Data_in_ins, Data_in_dram, dram_in;
  logic [15:0] key = '0;
  assign dram_in = 16'(addr_ext) * 16'd3 + key;

  host_mem_link dut (
    .clock(clock), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
    .addr_ext(addr_ext), .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
    .read_en_ext(read_en_ext), .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram), .dram_in(dram_in)
  );
  always #5 clock = ~clock;

  typedef struct packed {
    logic iram;
    logic [8:0] addr;
    logic [15:0] data;
    logic [3:0] len;
    logic ok;
  } wr_t;
  typedef struct {
    string nm;
    logic [15:0] w0, n, seed;
    int s_idx, s_len;
    logic [15:0] ack;
  } vec_t;
  wr_t wrs[$], exp_wr[$], cur;
  logic [15:0] rsps[$], exp_rsp[$];
  int runs[$];
  int exp_run, n_cmp = 0, n_bad = 0, proto_bad = 0, rd_rises = 0, run_len = 0, stab = 0;
  int stall_idx = -1, stall_left = 0;
  bit bp_rand = 1'b0;
  logic wr_q = 1'b0, re_q = 1'b0, st_q = 1'b0, rv_q = 1'b0, mode_q = 1'b0;
  logic [3:0] mode_seen = '0;
  logic [15:0] rd_q = '0, ins_q = '0, dr_q = '0;
  logic [8:0] ad_q = '0;
  vec_t vecs[9];

  // Protocol monitors plus the response sink; one block so rsp_ready ordering is deterministic.
  always @(negedge clock) begin
    logic wr, modes;
    wr = iram_write_ext | dram_write_ext;
    modes = start | start_2 | start_3 | start_4;
    mode_seen = mode_seen | {start_4, start_3, start_2, start};
    if (int'(start) + int'(start_2) + int'(start_3) + int'(start_4) > 1) proto_bad++;
    if (read_en_ext && rsp_valid) proto_bad++;
    if (rsp_valid && !rv_q && !modes && mode_q) proto_bad++;
    if (rv_q && !rsp_ready && (!rsp_valid || rsp_data != rd_q || addr_ext != ad_q)) proto_bad++;
    stab = (addr_ext == ad_q && Data_in_ins == ins_q && Data_in_dram == dr_q) ? stab + 1 : 0;
    if (wr && !wr_q) cur = '{iram_write_ext, addr_ext, iram_write_ext ? Data_in_ins : Data_in_dram, 4'd0, stab >= WR_SETUP};
    if (wr) begin
      cur.len = cur.len + 4'd1;
      if (addr_ext != cur.addr || (iram_write_ext ? Data_in_ins : Data_in_dram) != cur.data) cur.ok = 1'b0;
    end
    if (!wr && wr_q) begin
      if (addr_ext != cur.addr || (cur.iram ? Data_in_ins : Data_in_dram) != cur.data) cur.ok = 1'b0;
      wrs.push_back(cur);
    end
    if (read_en_ext && !re_q) rd_rises++;
    if (start) run_len++;
    else if (st_q) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    wr_q = wr; re_q = read_en_ext; st_q = start; mode_q = modes; rv_q = rsp_valid;
    rd_q = rsp_data; ad_q = addr_ext; ins_q = Data_in_ins; dr_q = Data_in_dram;
    if (rsp_valid && rsps.size() == stall_idx && stall_left > 0) begin
      rsp_ready = 1'b0;
      stall_left--;
    end else rsp_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (rsp_valid && rsp_ready) rsps.push_back(rsp_data);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int t = 0;
    @(negedge clock);
    cmd_data = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 5000) begin
      @(negedge clock);
      t++;
    end
    chk($sformatf("accept word %h", w), cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Expected transactions straight from the command semantics.
  task automatic model(input logic [3:0] op, input logic [8:0] a, input logic [15:0] n, input logic [15:0] seed);
    exp_rsp.delete();
    exp_wr.delete();
    exp_run = -1;
    if (op == 4'd0 || op > 4'd4) begin
      exp_rsp.push_back(16'hE000);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      logic [8:0] ai;
      ai = a + 9'(i);
      if (op == 4'd1 || op == 4'd2) exp_wr.push_back('{op == 4'd1, ai, seed + 16'(10 * i), 4'(WR_PULSE), 1'b1});
      if (op == 4'd4) exp_rsp.push_back(16'(ai) * 16'd3 + key);
    end
    if (op == 4'd3 && n != 0) exp_run = int'(n) * SCALE;
    exp_rsp.push_back({4'hA, op, 8'h00});
  endtask

  task automatic run_cmd(input string nm, input logic [15:0] w0, input logic [15:0] n, input logic [15:0] seed,
                         input int s_idx, input int s_len, input logic [15:0] ack);
    logic [3:0] op, exp_mode;
    bit bad;
    int t;
    op = w0[15:12];
    bad = op == 4'd0 || op > 4'd4;
    exp_mode = (bad || n == 0) ? 4'b0000 : op == 4'd3 ? 4'b0001 : op == 4'd1 ? 4'b0010 : op == 4'd2 ? 4'b0100 : 4'b1000;
    t = 0;
    model(op, w0[8:0], n, seed);
    wrs.delete(); runs.delete(); rsps.delete();
    rd_rises = 0; proto_bad = 0; mode_seen = '0;
    stall_idx = s_idx; stall_left = s_len;
    send(w0);
    if (!bad) send(n);
    if (!bad && (op == 4'd1 || op == 4'd2)) for (int i = 0; i < int'(n); i++) send(seed + 16'(10 * i));
    while (rsps.size() < exp_rsp.size() && t < 20000) begin
      @(negedge clock);
      t++;
    end
    repeat (4) @(negedge clock);
    chk({nm, " rsp count"}, rsps.size(), exp_rsp.size());
    foreach (exp_rsp[i]) if (i < rsps.size()) chk($sformatf("%s rsp[%0d]", nm, i), rsps[i], exp_rsp[i]);
    chk({nm, " ack"}, rsps.size() > 0 ? rsps[rsps.size() - 1] : 16'h0, ack);
    chk({nm, " write count"}, wrs.size(), exp_wr.size());
    foreach (exp_wr[i]) if (i < wrs.size()) chk($sformatf("%s write[%0d]", nm, i), wrs[i], exp_wr[i]);
    chk({nm, " run pulses"}, runs.size(), exp_run < 0 ? 0 : 1);
    if (runs.size() > 0 && exp_run >= 0) chk({nm, " run length"}, runs[0], exp_run);
    chk({nm, " read strobes"}, rd_rises, (op == 4'd4 && !bad) ? int'(n) : 0);
    chk({nm, " modes seen"}, mode_seen, exp_mode);
    chk({nm, " protocol"}, proto_bad, 0);
    chk({nm, " idle ready"}, cmd_ready, 1);
  endtask

  initial begin
    vecs[0] = '{"load_iram", 16'h1001, 16'd3, 16'd10, -1, 0, 16'hA100};
    vecs[1] = '{"load_dram_wrap", 16'h21FF, 16'd2, 16'h0100, -1, 0, 16'hA200};
    vecs[2] = '{"run4", 16'h3000, 16'd4, 16'd0, -1, 0, 16'hA300};
    vecs[3] = '{"read_bp", 16'h4005, 16'd3, 16'd0, 1, 10, 16'hA400};
    vecs[4] = '{"bad_op7", 16'h7123, 16'd0, 16'd0, -1, 0, 16'hE000};
    vecs[5] = '{"load_after_err", 16'h2010, 16'd1, 16'h1234, -1, 0, 16'hA200};
    vecs[6] = '{"load_n0", 16'h1000, 16'd0, 16'd0, -1, 0, 16'hA100};
    vecs[7] = '{"bad_op0", 16'h0000, 16'd0, 16'd0, -1, 0, 16'hE000};
    vecs[8] = '{"read_n0", 16'h4000, 16'd0, 16'd0, -1, 0, 16'hA400};
    @(negedge clock);
    chk("reset flags", {start, start_2, start_3, start_4, iram_write_ext, dram_write_ext, read_en_ext, rsp_valid, cmd_ready}, 9'h001);
    chk("reset addr/rsp", {addr_ext, rsp_data}, 0);
    chk("reset write data", {Data_in_ins, Data_in_dram}, 0);
    @(negedge clock);
    reset = 1'b0;
    foreach (vecs[i]) run_cmd(vecs[i].nm, vecs[i].w0, vecs[i].n, vecs[i].seed, vecs[i].s_idx, vecs[i].s_len, vecs[i].ack);
    begin
      int t = 0;
      send(16'h1001);
      send(16'd2);
      send(16'h0055);
      while (!iram_write_ext && t < 100) begin
        @(negedge clock);
        t++;
      end
      chk("rst reached pulse", iram_write_ext, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst async outputs", {start, start_2, start_3, start_4, iram_write_ext, dram_write_ext, read_en_ext, rsp_valid}, 0);
      chk("rst cmd_ready", cmd_ready, 1);
      @(negedge clock);
      reset = 1'b0;
      rsps.delete();
      repeat (20) @(negedge clock);
      chk("rst no ack", rsps.size(), 0);
    end
    bp_rand = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] op;
      logic [8:0] a;
      logic [15:0] n, seed;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(1, 4));
      a = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(508, 511)) : 9'($urandom);
      n = 16'(op == 4'd3 ? $urandom_range(0, 2) : $urandom_range(0, 4));
      seed = 16'($urandom);
      key = 16'($urandom);
      run_cmd($sformatf("rand%0d", k), {op, 3'b000, a}, n, seed, -1, 0,
              (op == 4'd0 || op > 4'd4) ? 16'hE000 : {4'hA, op, 8'h00});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
